// File: rtl/full_adder_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_bist_pkg
//  Purpose  : Shared constants for the full-adder BIST controller:
//             FSM state encoding, last sweep vector, mismatch-count ceiling.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package full_adder_bist_pkg;

    // Controller state encoding (2-bit)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Final vector of the sweep ({Cin,Y,X} = 111)
    localparam logic [2:0] VEC_LAST  = 3'd7;

    // Mismatch counter saturates here (one per vector at most)
    localparam logic [3:0] ERR_MAX   = 4'd8;

endpackage : full_adder_bist_pkg
`default_nettype wire

// File: rtl/fa_golden.sv
`default_nettype none
// ============================================================================
//  Module   : fa_golden
//  Purpose  : Combinational reference full adder used as the checker's
//             expected-value source.
//  Ports    : x, y, cin  - operand bits
//             sum, cout  - reference sum and carry-out
//  Revision : 1.0 - initial release
// ============================================================================
module fa_golden (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule : fa_golden
`default_nettype wire

// File: rtl/full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_bist
//  Purpose  : Built-in self-test controller for a 1-bit full adder. Sweeps
//             the eight {Cin,Y,X} vectors 000..111, holds each one for
//             SETTLE_CYCLES cycles, samples Sum/Cout and compares against
//             a golden model. Reports mismatch count, first failing vector
//             and pass/fail.
//  Ports    : clk, rst (sync, active-high), start
//             oX, oY, oCin      - registered operands to the adder
//             iSum, iCout       - adder response (synchronous to clk)
//             busy, done, pass  - status
//             err_cnt[3:0]      - mismatching vectors in last sweep (0..8)
//             fail_vec[2:0]     - {Cin,Y,X} of the first failing vector
//             inj_mask[1:0]     - only with FAULT_INJECT_EN: bit0 flips the
//                                 sampled Sum, bit1 flips the sampled Cout
//  Options  : FAULT_INJECT_EN   - adds the inj_mask port
//  Revision : 1.0 - initial release
// ============================================================================
module full_adder_bist
    import full_adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       oX,
    output logic       oY,
    output logic       oCin,
    input  logic       iSum,
    input  logic       iCout,
`ifdef FAULT_INJECT_EN
    input  logic [1:0] inj_mask,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec
);

    // Counter reload: it counts down to zero inclusive, so N-1 gives N cycles
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_check
            $error("SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    logic [1:0] r_state,    w_state_nxt;
    logic [2:0] r_vec,      w_vec_nxt;
    logic [3:0] r_cnt,      w_cnt_nxt;
    logic       r_busy,     w_busy_nxt;
    logic       r_done,     w_done_nxt;
    logic [3:0] r_err_cnt,  w_err_cnt_nxt;
    logic [2:0] r_fail_vec, w_fail_vec_nxt;

    // ------------------------------------------------------------------
    // Reference model and observed response
    // ------------------------------------------------------------------
    logic w_gold_sum;
    logic w_gold_cout;
    logic w_obs_sum;
    logic w_obs_cout;
    logic w_mismatch;

    fa_golden u_golden (
        .x    (r_vec[0]),
        .y    (r_vec[1]),
        .cin  (r_vec[2]),
        .sum  (w_gold_sum),
        .cout (w_gold_cout)
    );

`ifdef FAULT_INJECT_EN
    assign w_obs_sum  = iSum  ^ inj_mask[0];
    assign w_obs_cout = iCout ^ inj_mask[1];
`else
    assign w_obs_sum  = iSum;
    assign w_obs_cout = iCout;
`endif

    assign w_mismatch = (w_obs_sum != w_gold_sum) || (w_obs_cout != w_gold_cout);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vec      <= 3'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= 4'd0;
            r_fail_vec <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_fail_vec <= w_fail_vec_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_err_cnt_nxt  = r_err_cnt;
        w_fail_vec_nxt = r_fail_vec;

        case (r_state)
            // DONE restarts exactly like IDLE; results and the last vector
            // hold until then.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_vec_nxt      = 3'd0;
                    w_err_cnt_nxt  = 4'd0;
                    w_fail_vec_nxt = 3'd0;
                    w_cnt_nxt      = c_SETTLE_LOAD;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_state_nxt    = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_CHECK: begin
                if (w_mismatch) begin
                    if (r_err_cnt < ERR_MAX) begin
                        w_err_cnt_nxt = r_err_cnt + 4'd1;
                    end
                    // Only the first failing vector of a sweep is recorded
                    if (r_err_cnt == 4'd0) begin
                        w_fail_vec_nxt = r_vec;
                    end
                end
                if (r_vec == VEC_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_vec_nxt   = r_vec + 3'd1;
                    w_cnt_nxt   = c_SETTLE_LOAD;
                    w_state_nxt = ST_SETTLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (operands come straight from the vector register)
    // ------------------------------------------------------------------
    assign oX       = r_vec[0];
    assign oY       = r_vec[1];
    assign oCin     = r_vec[2];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_done && (r_err_cnt == 4'd0);
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule : full_adder_bist
`default_nettype wire
